// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the five-stage MIPS pipeline.
//
// In normal operation (RUN) the per-stage stall requests pass straight through
// to the 4-bit stall vector. The inter-stage registers resolve priority
// themselves: a higher index holds and a lower index inserts a bubble.
//
// When an exception or ERET commits at MEM, the sequencer does three things:
//   1. It flushes every pipeline register.
//   2. It waits in DRAIN while an instruction-bus transaction is still
//      outstanding, so that the late response is not taken as a fetch from
//      the new PC.
//   3. It spends one REDIRECT cycle pulsing pc_redirect_valid with the target
//      it latched earlier.
// A drain that never completes is cut off after DRAIN_TIMEOUT cycles and is
// flagged in drain_timeout_err.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   inst_req_stall         IF waiting on the instruction bus
//   id_req_stall           load-use / operand hazard in ID
//   ex_req_stall           multi-cycle mul/div busy in EX
//   mem_req_stall          MEM waiting on the data bus
//   mem_exception          exception or ERET committed at MEM this cycle
//   mem_exception_is_eret  qualifies mem_exception as ERET
//   cp0_epc                current CP0 EPC (the ERET target)
//   inst_bus_busy          instruction-bus transaction outstanding
//   stall[3:0]             {data, exe, id, inst} stall
//   flush                  clears all pipeline registers at the next edge
//   pc_redirect_valid      one-cycle pulse: PC loads pc_redirect_addr
//   pc_redirect_addr       redirect target (holds its value between pulses)
//   stall_cycles           saturating count of stalled RUN cycles
//   drain_timeout_err      sticky drain-timeout flag
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter logic [7:0]  DRAIN_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_stall,
    input  logic        id_req_stall,
    input  logic        ex_req_stall,
    input  logic        mem_req_stall,
    input  logic        mem_exception,
    input  logic        mem_exception_is_eret,
    input  logic [31:0] cp0_epc,
    input  logic        inst_bus_busy,
    output logic [3:0]  stall,
    output logic        flush,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_addr,
    output logic [31:0] stall_cycles,
    output logic        drain_timeout_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  drain_cnt_r;
    logic [7:0]  drain_cnt_next_s;
    logic [31:0] target_r;
    logic [31:0] target_next_s;
    logic [31:0] new_target_s;
    logic [31:0] addr_r;
    logic [31:0] stall_cycles_r;
    logic        err_r;
    logic        timeout_s;
    logic [3:0]  stall_s;
    logic        flush_s;
    logic        redirect_s;

    assign new_target_s = mem_exception_is_eret ? cp0_epc : EXC_VECTOR;

    // Next-state and output decode for the RUN / DRAIN / REDIRECT sequencer
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        target_next_s    = target_r;
        timeout_s        = 1'b0;
        stall_s          = 4'b0000;
        flush_s          = 1'b0;
        redirect_s       = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_exception) begin
                    // The exception wins over every stall request in the same cycle
                    flush_s          = 1'b1;
                    target_next_s    = new_target_s;
                    drain_cnt_next_s = 8'd0;
                    state_next_s     = inst_bus_busy ? DRAIN : REDIRECT;
                end else begin
                    stall_s      = {mem_req_stall, ex_req_stall, id_req_stall, inst_req_stall};
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                flush_s          = 1'b1;
                drain_cnt_next_s = drain_cnt_r + 8'd1;
                if (!inst_bus_busy) begin
                    state_next_s = REDIRECT;
                end else if (drain_cnt_next_s == DRAIN_TIMEOUT) begin
                    // The bus never went idle: give up and redirect anyway
                    timeout_s    = 1'b1;
                    state_next_s = REDIRECT;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            REDIRECT: begin
                // flush stays high so that the stale IF output is dropped
                flush_s      = 1'b1;
                redirect_s   = 1'b1;
                state_next_s = RUN;
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // State register and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            drain_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
        end
    end

    // Latched redirect target, and the address register that is loaded when
    // the sequencer enters REDIRECT
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r <= 32'h0000_0000;
            addr_r   <= 32'h0000_0000;
        end else begin
            target_r <= target_next_s;
            if (state_next_s == REDIRECT) begin
                addr_r <= target_next_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Sticky drain-timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | timeout_s;
        end
    end

    // Saturating stall-cycle counter. stall_s is only nonzero in RUN when
    // there is no exception in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if ((stall_s != 4'b0000) && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall             = stall_s;
    assign flush             = flush_s;
    assign pc_redirect_valid = redirect_s;
    assign pc_redirect_addr  = addr_r;
    assign stall_cycles      = stall_cycles_r;
    assign drain_timeout_err = err_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl. The bench runs these stages in order:
//   - a vector table covering stall pass-through, the stall-cycle count and
//     an exception while the bus is idle
//   - hand-written sequences for ERET with a drain, the drain timeout,
//     a reset in the middle of DRAIN, and counter saturation
//   - random stimulus compared against a behavioural model
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_stall = 1'b0;
    logic        id_req_stall = 1'b0;
    logic        ex_req_stall = 1'b0;
    logic        mem_req_stall = 1'b0;
    logic        mem_exception = 1'b0;
    logic        mem_exception_is_eret = 1'b0;
    logic [31:0] cp0_epc = 32'h0;
    logic        inst_bus_busy = 1'b0;
    logic [3:0]  stall;
    logic        flush;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_addr;
    logic [31:0] stall_cycles;
    logic        drain_timeout_err;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .inst_req_stall        (inst_req_stall),
        .id_req_stall          (id_req_stall),
        .ex_req_stall          (ex_req_stall),
        .mem_req_stall         (mem_req_stall),
        .mem_exception         (mem_exception),
        .mem_exception_is_eret (mem_exception_is_eret),
        .cp0_epc               (cp0_epc),
        .inst_bus_busy         (inst_bus_busy),
        .stall                 (stall),
        .flush                 (flush),
        .pc_redirect_valid     (pc_redirect_valid),
        .pc_redirect_addr      (pc_redirect_addr),
        .stall_cycles          (stall_cycles),
        .drain_timeout_err     (drain_timeout_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Input bits of v, from MSB to LSB: {inst, id, ex, mem, exc, eret, busy}.
    // Inputs are driven at the falling edge and checked 2 time units later.
    task automatic cyc(input logic [6:0] v, input logic [31:0] epc = 32'h0, input logic r = 1'b0);
        @(negedge clk);
        rst     = r;
        cp0_epc = epc;
        {inst_req_stall, id_req_stall, ex_req_stall, mem_req_stall,
         mem_exception, mem_exception_is_eret, inst_bus_busy} = v;
        #2;
    endtask

    task automatic do_reset();
        cyc(7'b0, 32'h0, 1'b1);
        cyc(7'b0, 32'h0, 1'b1);
    endtask

    typedef struct {
        logic [6:0]  in;
        logic [3:0]  st;
        logic        fl;
        logic        va;
        logic [31:0] ad;
        logic [31:0] cn;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model state
    bit          m_win;    // inside a drain window that follows an exception
    bit          m_redir;  // this cycle is the redirect cycle
    int          m_wait;   // drain cycles already spent
    logic [31:0] m_tgt;
    logic [31:0] m_addr;
    longint      m_cnt;
    bit          m_err;

    task automatic model_reset();
        m_win   = 1'b0;
        m_redir = 1'b0;
        m_wait  = 0;
        m_tgt   = 32'h0;
        m_addr  = 32'h0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  v;
        logic        r;
        logic [31:0] epc;
        logic [3:0]  e_st;
        logic        e_fl;
        logic        e_va;
        logic [31:0] e_ad;
        int          busy_pct;

        // ---------------- table-driven vectors ----------------
        tbl[0]  = '{7'b0000_000, 4'b0000, 1'b0, 1'b0, 32'h0, 32'd0};
        tbl[1]  = '{7'b1001_000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'd0};
        tbl[2]  = '{7'b1001_000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'd1};
        tbl[3]  = '{7'b1001_000, 4'b1001, 1'b0, 1'b0, 32'h0, 32'd2};
        tbl[4]  = '{7'b0100_000, 4'b0010, 1'b0, 1'b0, 32'h0, 32'd3};
        tbl[5]  = '{7'b0010_000, 4'b0100, 1'b0, 1'b0, 32'h0, 32'd4};
        tbl[6]  = '{7'b1111_000, 4'b1111, 1'b0, 1'b0, 32'h0, 32'd5};
        tbl[7]  = '{7'b0010_100, 4'b0000, 1'b1, 1'b0, 32'h0, 32'd6};
        tbl[8]  = '{7'b1000_000, 4'b0000, 1'b1, 1'b1, VEC,   32'd6};
        tbl[9]  = '{7'b0000_000, 4'b0000, 1'b0, 1'b0, VEC,   32'd6};
        tbl[10] = '{7'b0100_000, 4'b0010, 1'b0, 1'b0, VEC,   32'd6};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].in);
            chk($sformatf("tbl%0d.stall", i), 64'(stall), 64'(tbl[i].st));
            chk($sformatf("tbl%0d.flush", i), 64'(flush), 64'(tbl[i].fl));
            chk($sformatf("tbl%0d.valid", i), 64'(pc_redirect_valid), 64'(tbl[i].va));
            chk($sformatf("tbl%0d.addr", i), 64'(pc_redirect_addr), 64'(tbl[i].ad));
            chk($sformatf("tbl%0d.cnt", i), 64'(stall_cycles), 64'(tbl[i].cn));
            chk($sformatf("tbl%0d.err", i), 64'(drain_timeout_err), 64'(1'b0));
        end

        // ---------------- ERET with a 4-cycle drain ----------------
        do_reset();
        cyc(7'b1000_111, 32'h80001234);
        chk("eret.t0", 64'({stall, flush, pc_redirect_valid}), 64'(6'b0000_1_0));
        for (int i = 1; i <= 4; i++) begin
            // A second exception during the drain must be ignored
            cyc({1'b1, 3'b000, (i == 2), 1'b0, (i < 4)}, 32'h0000_5555);
            chk($sformatf("eret.drain%0d", i), 64'({stall, flush, pc_redirect_valid}), 64'(6'b0000_1_0));
        end
        cyc(7'b1000_000);
        chk("eret.redir", 64'({stall, flush, pc_redirect_valid}), 64'(6'b0000_1_1));
        chk("eret.addr", 64'(pc_redirect_addr), 64'(32'h80001234));
        cyc(7'b1000_000);
        chk("eret.run", 64'({stall, flush, pc_redirect_valid}), 64'(6'b0001_0_0));
        chk("eret.addr_hold", 64'(pc_redirect_addr), 64'(32'h80001234));
        chk("eret.cnt0", 64'(stall_cycles), 64'(32'd0));
        cyc(7'b0000_000);
        chk("eret.cnt1", 64'(stall_cycles), 64'(32'd1));

        // ---------------- drain timeout, then reset mid-DRAIN ----------------
        do_reset();
        cyc(7'b0000_101);
        chk("tmo.t0", 64'({flush, pc_redirect_valid}), 64'(2'b10));
        for (int k = 1; k <= 255; k++) begin
            cyc(7'b0000_001);
            chk($sformatf("tmo.drain%0d", k), 64'({flush, pc_redirect_valid, drain_timeout_err}), 64'(3'b100));
        end
        cyc(7'b0000_001);
        chk("tmo.redir", 64'({flush, pc_redirect_valid, drain_timeout_err}), 64'(3'b111));
        chk("tmo.addr", 64'(pc_redirect_addr), 64'(VEC));
        cyc(7'b1000_000);
        chk("tmo.run", 64'({stall, flush, drain_timeout_err}), 64'(6'b0001_0_1));
        cyc(7'b1000_000);
        chk("tmo.sticky", 64'({drain_timeout_err, stall_cycles}), 64'({1'b1, 32'd1}));
        cyc(7'b0000_101);
        cyc(7'b0000_001);
        cyc(7'b0000_001);
        cyc(7'b0000_001, 32'h0, 1'b1);
        cyc(7'b0000_000);
        chk("rst.ctrl", 64'({stall, flush, pc_redirect_valid, drain_timeout_err}), 64'(7'b0));
        chk("rst.addr", 64'(pc_redirect_addr), 64'(32'h0));
        chk("rst.cnt", 64'(stall_cycles), 64'(32'd0));
        cyc(7'b0000_000);
        chk("rst.nopulse", 64'({flush, pc_redirect_valid}), 64'(2'b00));

        // ---------------- stall counter saturation ----------------
        do_reset();
        cyc(7'b0);
        force dut.stall_cycles_r = 32'hFFFF_FFFD;
        cyc(7'b0);
        release dut.stall_cycles_r;
        cyc(7'b0001_000);
        chk("sat.fd", 64'(stall_cycles), 64'(32'hFFFF_FFFD));
        cyc(7'b0001_000);
        chk("sat.fe", 64'(stall_cycles), 64'(32'hFFFF_FFFE));
        cyc(7'b0001_000);
        chk("sat.ff", 64'(stall_cycles), 64'(32'hFFFF_FFFF));
        cyc(7'b0001_000);
        chk("sat.hold1", 64'(stall_cycles), 64'(32'hFFFF_FFFF));
        cyc(7'b0000_000);
        chk("sat.hold2", 64'(stall_cycles), 64'(32'hFFFF_FFFF));

        // ---------------- random stimulus against the model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            busy_pct = (((n / 150) % 2) == 0) ? 15 : 90;
            v[6:3] = 4'($urandom);
            v[2]   = ($urandom_range(0, 99) < 6);
            v[1]   = 1'($urandom);
            v[0]   = ($urandom_range(0, 99) < busy_pct);
            r      = ($urandom_range(0, 199) == 0);
            epc    = $urandom;

            e_st = 4'b0000;
            e_va = 1'b0;
            e_ad = m_addr;
            if (m_redir) begin
                e_fl = 1'b1;
                e_va = 1'b1;
                e_ad = m_tgt;
            end else if (m_win || v[2]) begin
                e_fl = 1'b1;
            end else begin
                e_fl = 1'b0;
                e_st = {v[3], v[4], v[5], v[6]};
            end

            cyc(v, epc, r);
            chk($sformatf("rand%0d.ctrl", n), 64'({stall, flush, pc_redirect_valid, drain_timeout_err}),
                64'({e_st, e_fl, e_va, m_err}));
            chk($sformatf("rand%0d.addr", n), 64'(pc_redirect_addr), 64'(e_ad));
            chk($sformatf("rand%0d.cnt", n), 64'(stall_cycles), 64'(m_cnt));

            if (r) begin
                model_reset();
            end else if (m_redir) begin
                m_addr  = m_tgt;
                m_redir = 1'b0;
            end else if (m_win) begin
                m_wait++;
                if (!v[0]) begin
                    m_win   = 1'b0;
                    m_redir = 1'b1;
                end else if (m_wait == 255) begin
                    m_err   = 1'b1;
                    m_win   = 1'b0;
                    m_redir = 1'b1;
                end
            end else if (v[2]) begin
                m_tgt = v[1] ? epc : VEC;
                if (v[0]) begin
                    m_win  = 1'b1;
                    m_wait = 0;
                end else begin
                    m_redir = 1'b1;
                end
            end else if ((v[6:3] != 4'b0000) && (m_cnt < 64'hFFFF_FFFF)) begin
                m_cnt++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline.
- Merges per-stage stall requests into the 4-bit stall vector consumed by every inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- On an exception or ERET committed at MEM, flushes all pipeline registers, waits for any outstanding instruction-bus transaction to drain, then issues a one-cycle PC redirect.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- DRAIN_TIMEOUT, 255, max cycles in DRAIN before forced redirect; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_req_stall  in  1  IF waiting on instruction bus
- id_req_stall  in  1  load-use / operand hazard in ID
- ex_req_stall  in  1  multi-cycle mul/div busy in EX
- mem_req_stall  in  1  MEM waiting on data bus
- mem_exception  in  1  exception or ERET committed at MEM this cycle
- mem_exception_is_eret  in  1  qualifies mem_exception as ERET
- cp0_epc  in  32  current CP0 EPC
- inst_bus_busy  in  1  instruction-bus transaction outstanding
- stall  out  4  [0] inst_stall, [1] id_stall, [2] exe_stall, [3] data_stall
- flush  out  1  clears all pipeline registers at the next edge
- pc_redirect_valid  out  1  one-cycle pulse: PC loads pc_redirect_addr
- pc_redirect_addr  out  32  redirect target
- stall_cycles  out  32  saturating count of stalled RUN cycles
- drain_timeout_err  out  1  sticky: drain exceeded DRAIN_TIMEOUT

Behaviour:
- Reset rst is synchronous and active-high; clock clk.
- Reset values: state = RUN; stall = 0, flush = 0, pc_redirect_valid = 0, pc_redirect_addr = 0, stall_cycles = 0, drain_timeout_err = 0; target register and drain counter = 0.
- Reset in any state returns to RUN on the next edge. Any pending redirect is discarded.
- FSM states: RUN, DRAIN, REDIRECT.
- stall (combinational, RUN only and no mem_exception):
  - stall[3] = mem_req_stall
  - stall[2] = ex_req_stall
  - stall[1] = id_req_stall
  - stall[0] = inst_req_stall
  - Raw requests pass through. Pipeline registers resolve priority (higher index holds, lower index inserts a bubble).
  - stall = 4'b0000 whenever flush = 1, and in DRAIN and REDIRECT.
- flush (combinational) = (RUN and mem_exception) or DRAIN or REDIRECT.
- RUN with mem_exception:
  - Latch target = mem_exception_is_eret ? cp0_epc : EXC_VECTOR.
  - Clear the drain counter.
  - Next state = DRAIN if inst_bus_busy, else REDIRECT.
  - mem_exception has priority over all stall requests in the same cycle.
- DRAIN:
  - Increment the drain counter each cycle.
  - Leave for REDIRECT when inst_bus_busy = 0.
  - If the counter reaches DRAIN_TIMEOUT with the bus still busy: set drain_timeout_err (sticky until rst) and go to REDIRECT anyway.
- REDIRECT (exactly one cycle):
  - pc_redirect_valid = 1, pc_redirect_addr = latched target. flush stays 1 so the stale IF output is dropped.
  - Next state = RUN.
- pc_redirect_addr holds its last value outside REDIRECT.
- mem_exception is ignored in DRAIN and REDIRECT; the pipeline is empty by construction.
- stall_cycles: +1 on each RUN cycle with stall != 0. Saturates at 32'hFFFFFFFF with no wrap. Does not count in DRAIN or REDIRECT.
- Exception-to-redirect latency: 1 cycle when the bus is idle (exception cycle, then REDIRECT); 1 + N cycles when the bus stays busy N cycles.

Test Plan:
- Reset, then inst_req_stall=1 and mem_req_stall=1 for 3 cycles -> stall=4'b1001 each cycle, flush=0, stall_cycles=3.
- mem_exception=1, is_eret=0, inst_bus_busy=0 at cycle t -> flush=1 at t and t+1; pc_redirect_valid=1 at t+1 with addr 32'hBFC00380; back in RUN at t+2.
- ERET with cp0_epc=32'h80001234, inst_bus_busy held 4 cycles -> flush high 6 cycles (t, 4×DRAIN, REDIRECT); redirect pulse to 32'h80001234 at t+5; stall=0 throughout.
- mem_exception coincident with ex_req_stall=1 -> stall=0, flush=1, stall_cycles unchanged.
- inst_bus_busy stuck high after an exception -> after DRAIN_TIMEOUT cycles in DRAIN: drain_timeout_err=1, redirect issued; err stays 1 until rst.
- rst asserted mid-DRAIN -> next cycle: RUN, no redirect pulse, all outputs at reset values; preload stall_cycles near 32'hFFFFFFFF in a separate run to confirm saturation.
